// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with an optional two-entry skid buffer.
// It also keeps saturating stall and bubble counters for pipeline performance analysis.
module pipe_stage_buf #(
  parameter int DATA_W  = 32,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] main_p0, main_nxt;
  logic              in_fire;
  logic              out_fire;
  logic              stall_cyc;
  logic              bubble_cyc;
  logic [CNT_W-1:0]  stall_p0;
  logic [CNT_W-1:0]  bubble_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign out_valid_o = (state_p0 != ST_EMPTY);
  assign out_data_o  = main_p0;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  if (SKID_EN != 0) begin : g_skid
    logic [DATA_W-1:0] skid_p0, skid_nxt;

    // Ready is a pure decode of the state register, so out_ready_i never reaches it.
    assign in_ready_o = (state_p0 != ST_SKID);

    always_comb begin
      state_nxt = state_p0;
      main_nxt  = main_p0;
      skid_nxt  = skid_p0;
      if (flush_i) begin
        state_nxt = ST_EMPTY;
        main_nxt  = '0;
        skid_nxt  = '0;
      end else begin
        case (state_p0)
          ST_EMPTY: begin
            if (in_fire) begin
              state_nxt = ST_FULL;
              main_nxt  = in_data_i;
            end
          end
          ST_FULL: begin
            if (in_fire && out_fire) begin
              main_nxt = in_data_i;
            end else if (in_fire) begin
              state_nxt = ST_SKID;
              skid_nxt  = in_data_i;
            end else if (out_fire) begin
              state_nxt = ST_EMPTY;
            end
          end
          ST_SKID: begin
            // Skid entry is always younger than main, so it moves up on drain.
            if (out_fire) begin
              state_nxt = ST_FULL;
              main_nxt  = skid_p0;
            end
          end
          default: begin
            state_nxt = ST_EMPTY;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_p0 <= '0;
      end else begin
        skid_p0 <= skid_nxt;
      end
    end
  end else begin : g_noskid
    assign in_ready_o = !out_valid_o || out_ready_i;

    always_comb begin
      state_nxt = state_p0;
      main_nxt  = main_p0;
      if (flush_i) begin
        state_nxt = ST_EMPTY;
        main_nxt  = '0;
      end else if (in_fire) begin
        state_nxt = ST_FULL;
        main_nxt  = in_data_i;
      end else if (out_fire) begin
        state_nxt = ST_EMPTY;
      end
    end
  end

  // Stage register boundary: state and main payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_EMPTY;
      main_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      main_p0  <= main_nxt;
    end
  end

  assign stall_cyc  = out_valid_o && !out_ready_i && !flush_i;
  assign bubble_cyc = !out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_p0  <= '0;
      bubble_p0 <= '0;
    end else begin
      if (stall_cyc) begin
        stall_p0 <= sat_inc(stall_p0);
      end
      if (bubble_cyc) begin
        bubble_p0 <= sat_inc(bubble_p0);
      end
    end
  end

  assign stall_cnt_o  = stall_p0;
  assign bubble_cnt_o = bubble_p0;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid, non-skid and 4-bit-counter instances share one stimulus.
// A queue-based model of each stage tracks the expected outputs.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        v0, v1, v2, r0, r1, r2;
  logic [31:0] d0, d1, d2;
  logic [15:0] s0, s1, b0, b1;
  logic [3:0]  s2, b2;

  logic        dv[3];
  logic        dr[3];
  logic [31:0] dd[3];
  logic [15:0] ds[3];
  logic [15:0] db[3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .SKID_EN(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r0),
    .in_data_i(in_data), .out_valid_o(v0), .out_ready_i(out_ready), .out_data_o(d0),
    .stall_cnt_o(s0), .bubble_cnt_o(b0));

  pipe_stage_buf #(.DATA_W(32), .SKID_EN(0), .CNT_W(16)) u_flow (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r1),
    .in_data_i(in_data), .out_valid_o(v1), .out_ready_i(out_ready), .out_data_o(d1),
    .stall_cnt_o(s1), .bubble_cnt_o(b1));

  pipe_stage_buf #(.DATA_W(32), .SKID_EN(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r2),
    .in_data_i(in_data), .out_valid_o(v2), .out_ready_i(out_ready), .out_data_o(d2),
    .stall_cnt_o(s2), .bubble_cnt_o(b2));

  always_comb begin
    dv[0] = v0; dv[1] = v1; dv[2] = v2;
    dr[0] = r0; dr[1] = r1; dr[2] = r2;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    ds[0] = s0; ds[1] = s1; ds[2] = {12'd0, s2};
    db[0] = b0; db[1] = b1; db[2] = {12'd0, b2};
  end

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [31:0] mq[3][$];
  logic [31:0] mlast[3] = '{32'd0, 32'd0, 32'd0};
  int          mstall[3] = '{0, 0, 0};
  int          mbub[3] = '{0, 0, 0};
  bit          mskid[3] = '{1'b1, 1'b0, 1'b1};
  int          mmax[3] = '{65535, 65535, 15};

  function automatic bit m_valid(int i);
    return mq[i].size() != 0;
  endfunction

  function automatic bit m_ready(int i);
    if (mskid[i]) return mq[i].size() < 2;
    return (mq[i].size() == 0) || out_ready;
  endfunction

  function automatic logic [31:0] m_data(int i);
    return (mq[i].size() != 0) ? mq[i][0] : mlast[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit fi, fo, v;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        mlast[i] = '0;
        mstall[i] = 0;
        mbub[i] = 0;
      end else begin
        v  = m_valid(i);
        fi = in_valid && m_ready(i);
        fo = v && out_ready;
        if (flush) begin
          mq[i].delete();
          mlast[i] = '0;
        end else begin
          if (v && !out_ready && mstall[i] < mmax[i]) mstall[i]++;
          if (!v && out_ready && mbub[i] < mmax[i]) mbub[i]++;
          if (fo) mlast[i] = mq[i].pop_front();
          if (fi) mq[i].push_back(in_data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0d want 0", v0); end
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL rst_ready_skid: got %0d want 1", r0); end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL rst_ready_flow: got %0d want 1", r1); end
    n_cmp++; if (d0 !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", d0); end
    n_cmp++; if (s0 !== 16'd0 || b0 !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", s0, b0); end
    // Drive the skid instance into SKID, then reset mid-cycle
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; in_data = 32'd1; out_ready = 1'b0;
    @(negedge clk); in_data = 32'd2;
    @(negedge clk); #1;
    n_cmp++; if (r0 !== 1'b0) begin n_err++; $display("FAIL pre_rst_skid_ready: got %0d want 0", r0); end
    n_cmp++; if (s0 !== 16'd1) begin n_err++; $display("FAIL pre_rst_stall: got %0d want 1", s0); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %0d want 0", v0); end
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %0d want 1", r0); end
    n_cmp++; if (d0 !== 32'd0) begin n_err++; $display("FAIL async_rst_data: got %h want 0", d0); end
    n_cmp++; if (s0 !== 16'd0 || b0 !== 16'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d/%0d want 0/0", s0, b0); end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1; #1;
    n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL a5_before: got %0d want 0", v0); end
    @(negedge clk); in_valid = 1'b0; #1;
    n_cmp++; if (v0 !== 1'b1 || d0 !== 32'hA5) begin n_err++; $display("FAIL a5_latency: got %0d/%h want 1/a5", v0, d0); end
    @(negedge clk); #1;
    n_cmp++; if (v0 !== 1'b0 || d0 !== 32'hA5) begin n_err++; $display("FAIL a5_drain_hold: got %0d/%h want 0/a5", v0, d0); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i > 1) begin
        n_cmp++; if (v0 !== 1'b1 || d0 !== 32'(i - 1)) begin n_err++; $display("FAIL stream_skid[%0d]: got %0d/%h want 1/%h", i - 1, v0, d0, i - 1); end
        n_cmp++; if (v1 !== 1'b1 || d1 !== 32'(i - 1)) begin n_err++; $display("FAIL stream_flow[%0d]: got %0d/%h want 1/%h", i - 1, v1, d1, i - 1); end
      end
      in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1; #1;
      n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %0d want 1", i, r0); end
    end
    @(negedge clk);
    n_cmp++; if (v0 !== 1'b1 || d0 !== 32'd8) begin n_err++; $display("FAIL stream_skid[8]: got %0d/%h want 1/8", v0, d0); end
    in_valid = 1'b0; #1;
    n_cmp++; if (s0 !== 16'd0) begin n_err++; $display("FAIL stream_stall: got %0d want 0", s0); end
    @(negedge clk); #1;
    n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %0d want 0", v0); end
  endtask

  task automatic test_backpressure();
    int st0;
    st0 = int'(s0);
    @(negedge clk); in_valid = 1'b1; in_data = 32'h10; out_ready = 1'b1; #1;
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL bp_ready_a: got %0d want 1", r0); end
    @(negedge clk); in_data = 32'h11; out_ready = 1'b0; #1;
    n_cmp++; if (v0 !== 1'b1 || d0 !== 32'h10 || r0 !== 1'b1) begin n_err++; $display("FAIL bp_full: got %0d/%h/%0d want 1/10/1", v0, d0, r0); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_data = 32'h12; #1;
      n_cmp++; if (r0 !== 1'b0 || d0 !== 32'h10) begin n_err++; $display("FAIL bp_skid[%0d]: got %0d/%h want 0/10", k, r0, d0); end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    n_cmp++; if (d0 !== 32'h10 || r0 !== 1'b0) begin n_err++; $display("FAIL bp_out0: got %h/%0d want 10/0", d0, r0); end
    @(negedge clk); #1;
    n_cmp++; if (d0 !== 32'h11 || r0 !== 1'b1) begin n_err++; $display("FAIL bp_out1: got %h/%0d want 11/1", d0, r0); end
    @(negedge clk); in_valid = 1'b0; #1;
    n_cmp++; if (v0 !== 1'b1 || d0 !== 32'h12) begin n_err++; $display("FAIL bp_out2: got %0d/%h want 1/12", v0, d0); end
    @(negedge clk); #1;
    n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %0d want 0", v0); end
    n_cmp++; if (int'(s0) - st0 !== 4) begin n_err++; $display("FAIL bp_stall: got %0d want 4", int'(s0) - st0); end
  endtask

  task automatic test_flush_skid();
    int st;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h20; out_ready = 1'b0;
    @(negedge clk); in_data = 32'h21;
    @(negedge clk); #1;
    n_cmp++; if (r0 !== 1'b0 || d0 !== 32'h20) begin n_err++; $display("FAIL fl_skid: got %0d/%h want 0/20", r0, d0); end
    st = int'(s0);
    in_data = 32'h22; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    n_cmp++; if (v0 !== 1'b0 || d0 !== 32'd0 || r0 !== 1'b1) begin n_err++; $display("FAIL fl_after: got %0d/%h/%0d want 0/0/1", v0, d0, r0); end
    n_cmp++; if (int'(s0) !== st) begin n_err++; $display("FAIL fl_stall: got %0d want %0d", s0, st); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (v0 !== 1'b0) begin n_err++; $display("FAIL fl_no_out[%0d]: got %0d/%h want 0", k, v0, d0); end
    end
  endtask

  task automatic test_noskid();
    @(negedge clk); in_valid = 1'b1; in_data = 32'h30; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
    n_cmp++; if (r1 !== 1'b0 || v1 !== 1'b1 || d1 !== 32'h30) begin n_err++; $display("FAIL ns_block: got %0d/%0d/%h want 0/1/30", r1, v1, d1); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h33; #1;
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL ns_comb_ready: got %0d want 1", r1); end
    @(negedge clk); in_valid = 1'b0; #1;
    n_cmp++; if (v1 !== 1'b1 || d1 !== 32'h33) begin n_err++; $display("FAIL ns_next: got %0d/%h want 1/33", v1, d1); end
    @(negedge clk); #1;
    n_cmp++; if (v1 !== 1'b0 || d1 !== 32'h33) begin n_err++; $display("FAIL ns_hold: got %0d/%h want 0/33", v1, d1); end
  endtask

  task automatic test_counter_sat();
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h40; #1;
    n_cmp++; if (s2 !== 4'd0 || b2 !== 4'd0) begin n_err++; $display("FAIL sat_start: got %0d/%0d want 0/0", s2, b2); end
    @(negedge clk); in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (s2 !== 4'((k > 15) ? 15 : k)) begin n_err++; $display("FAIL sat_stall[%0d]: got %0d want %0d", k, s2, (k > 15) ? 15 : k); end
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (v2 !== 1'b0 || b2 !== 4'd0) begin n_err++; $display("FAIL sat_drain: got %0d/%0d want 0/0", v2, b2); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (b2 !== 4'((k > 15) ? 15 : k)) begin n_err++; $display("FAIL sat_bubble[%0d]: got %0d want %0d", k, b2, (k > 15) ? 15 : k); end
    end
    n_cmp++; if (s2 !== 4'd15) begin n_err++; $display("FAIL sat_stall_hold: got %0d want 15", s2); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      in_data   = $urandom;
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (dv[i] !== m_valid(i)) begin n_err++; $display("FAIL rnd_valid[%0d] cyc %0d: got %0d want %0d", i, c, dv[i], m_valid(i)); end
        n_cmp++; if (dr[i] !== m_ready(i)) begin n_err++; $display("FAIL rnd_ready[%0d] cyc %0d: got %0d want %0d", i, c, dr[i], m_ready(i)); end
        n_cmp++; if (dd[i] !== m_data(i)) begin n_err++; $display("FAIL rnd_data[%0d] cyc %0d: got %h want %h", i, c, dd[i], m_data(i)); end
        n_cmp++; if (int'(ds[i]) !== mstall[i]) begin n_err++; $display("FAIL rnd_stall[%0d] cyc %0d: got %0d want %0d", i, c, ds[i], mstall[i]); end
        n_cmp++; if (int'(db[i]) !== mbub[i]) begin n_err++; $display("FAIL rnd_bubble[%0d] cyc %0d: got %0d want %0d", i, c, db[i], mbub[i]); end
      end
    end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_noskid();
    test_counter_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic parametrised pipeline stage register that carries an opaque payload between two pipeline stages (e.g. decode->execute, execute->LSU).
- Replaces the per-stage stall/flush registers with a valid/ready handshake, so several stages can be chained without a central stall vector.
- Optional two-entry skid mode: upstream ready is registered and throughput stays at 1 transfer/cycle.
- Built-in stall and bubble counters support pipeline performance analysis.

Parameters:
DATA_W, 32, payload width in bits (>=1)
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready
CNT_W, 16, width of the stall and bubble counters (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
flush_i  input  1  synchronous flush, highest priority, discards all held entries
in_valid_i  input  1  upstream payload valid
in_ready_o  output  1  stage can accept the upstream payload
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  downstream payload valid
out_ready_i  input  1  downstream accepts the payload
out_data_o  output  DATA_W  downstream payload (main register)
stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0
bubble_cnt_o  output  CNT_W  cycles with out_valid_o=0 and out_ready_i=1

Behaviour:
- Definitions: in_fire = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i.
- Reset (async, rst_n=0):
  - State EMPTY; out_valid_o=0; main and skid registers=0; out_data_o=0; both counters=0.
  - in_ready_o=1 in both modes.
- Flush (flush_i=1 at clock edge): state -> EMPTY; main and skid registers cleared to 0; out_valid_o=0 next cycle.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle is still counted as consumed by downstream; the stage does not replay it.
  - Counters are not cleared by flush.
- SKID_EN=1, states EMPTY / FULL / SKID:
  - in_ready_o = (state != SKID), registered; it does not depend on out_ready_i.
  - out_valid_o = (state != EMPTY).
  - EMPTY: in_fire -> FULL, main<=in_data_i.
  - FULL, in_fire & out_fire -> FULL, main<=in_data_i.
  - FULL, in_fire & !out_fire -> SKID, skid<=in_data_i, main unchanged.
  - FULL, !in_fire & out_fire -> EMPTY.
  - FULL, otherwise -> hold.
  - SKID: out_fire -> FULL, main<=skid. Otherwise hold. in_valid_i is ignored (in_ready_o=0).
  - Ordering is strictly FIFO: main is always older than skid.
- SKID_EN=0, states EMPTY / FULL:
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - in_fire loads main and sets FULL. out_fire without in_fire -> EMPTY.
  - Simultaneous in_fire and out_fire -> FULL with the new payload.
  - Skid register is not instantiated.
- Latency: a payload accepted at edge N appears on out_data_o with out_valid_o=1 after edge N (1 cycle) in both modes when the stage was EMPTY or draining.
- Throughput: 1 payload/cycle sustained in both modes when out_ready_i=1.
- out_data_o keeps its last value when EMPTY after a normal drain. It reads 0 only after reset or flush.
- Counters:
  - Each counter increments by 1 on the qualifying cycle.
  - Each saturates at all-ones and does not wrap.
  - Neither counts on a cycle where flush_i=1.
- Input stability: downstream may drop out_ready_i at any time. Upstream must hold in_data_i stable while in_valid_i=1 and in_ready_o=0; the stage does not check this.
- No combinational path from in_valid_i to out_valid_o. With SKID_EN=1 there is also no path from out_ready_i to in_ready_o.

Test Plan:
- Reset: assert rst_n=0 mid-stream with state SKID -> out_valid_o=0, in_ready_o=1, out_data_o=0, both counters=0 immediately (asynchronous). After release, first payload 0xA5 appears one cycle after acceptance.
- Streaming (SKID_EN=1, DATA_W=32): out_ready_i=1, in_valid_i=1 for 8 cycles with data 1..8 -> out_data_o shows 1..8 on consecutive cycles, in_ready_o stays 1, stall_cnt_o=0.
- Backpressure: stream 0x10,0x11,0x12 with out_ready_i=0 from the second cycle.
  - State goes FULL then SKID; in_ready_o=0; 0x12 is held upstream.
  - Release out_ready_i -> outputs 0x10, 0x11, 0x12 in order, with no loss or duplication.
  - stall_cnt_o equals the number of stalled cycles.
- Flush in SKID: hold 0x20/0x21 in main/skid, then pulse flush_i with in_valid_i=1 (0x22) -> next cycle out_valid_o=0, out_data_o=0, in_ready_o=1. 0x20, 0x21 and 0x22 are never output.
- SKID_EN=0 mode: out_ready_i=0 while FULL -> in_ready_o=0 in the same cycle. Raise out_ready_i with in_valid_i=1 (0x33) -> in_ready_o=1 in the same cycle, 0x33 appears next cycle.
- Counter saturation (CNT_W=4): hold out_valid_o=1 and out_ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays at 15. Hold EMPTY with out_ready_i=1 for 20 cycles -> bubble_cnt_o=15.
